control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that drives the Datapath's bus-select, register-load and ALU-select signals through fetch and execute steps T0..T6.
- Replaces hand-sequenced testbench stimulus.
- Supports register-register ALU ops, two-operand ops (neg/not), mul/div to HI/LO, nop and halt.
- Memory read uses a ready handshake.

Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-high reset
- run  in  1  start/continue execution
- mem_rdy  in  1  memory data valid for current Read
- ir  in  32  current IR contents from datapath
- R_rd  out  16  one-hot register load enables (bus -> Rn)
- R_wrt  out  16  one-hot register bus drive enables (Rn -> bus)
- PC_out, MDR_out, Zlo_out, Zhi_out  out  1 each  bus drive selects
- MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, LO_rd, HI_rd  out  1 each  register load enables
- IncPC  out  1  ALU computes PC+1
- Read  out  1  memory read strobe, MDR takes Mdatain
- op_sel  out  5  ALU operation select
- busy  out  1  state not IDLE/HALT
- halted  out  1  in HALT
- illegal  out  1  sticky, illegal opcode seen
- instr_cnt  out  CNT_W  retired instructions

Behaviour:
- IR fields: opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
- Opcode classes:
  - 3REG: 00011..01100, Ra <- Rb op Rc
  - MULDIV: 01111, 10000, {HI,LO} <- Rb op Rc
  - 2REG: 10001 (neg), 10010 (not), Ra <- op Rb
  - NOP: 11010
  - HALT: 11011
  - all others ILLEGAL
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. State register with async clr.
- Outputs are combinational from state and ir only. Each output is held for the whole state cycle; datapath captures on the next rising edge. All unlisted outputs are 0. op_sel=0 except where stated.
- IDLE: all controls 0. Go to T0 when run=1.
- T0: PC_out, MAR_rd, IncPC, Zlo_rd.
- T1: Zlo_out, PC_rd, Read, MDR_rd.
  - Stay in T1 while mem_rdy=0.
  - PC_rd is asserted only in the cycle mem_rdy=1, so PC loads exactly once.
  - Read and MDR_rd stay high across all wait cycles.
- T2: MDR_out, IR_rd.
- T3 by class:
  - 3REG/MULDIV: R_wrt[Rb], Y_rd.
  - 2REG: R_wrt[Rb], op_sel=opcode, Zlo_rd.
  - NOP/ILLEGAL: nothing; set illegal if ILLEGAL.
  - HALT: nothing, next state HALT.
- T4:
  - 3REG: R_wrt[Rc], op_sel=opcode, Zlo_rd.
  - MULDIV: same plus Zhi_rd.
  - 2REG: Zlo_out, R_rd[Ra] (last step).
- T5:
  - 3REG: Zlo_out, R_rd[Ra] (last step).
  - MULDIV: Zlo_out, LO_rd.
- T6 (MULDIV only): Zhi_out, HI_rd (last step).
- Completion (last step of any class, including T3 for NOP/ILLEGAL):
  - instr_cnt increments on that edge and wraps at all-ones to 0.
  - Next state T0 if run=1, else IDLE.
  - run is sampled only at IDLE and at completion; deasserting mid-instruction finishes the instruction.
- HALT: all controls 0, halted=1, instr_cnt increments once on entry. Only clr exits.
- Mutual exclusion: at most one bus driver (R_wrt bits, PC_out, MDR_out, Zlo_out, Zhi_out) is asserted in any cycle. R_rd and R_wrt are zero or one-hot.
- clr at any time, including mid-T1 wait: immediately IDLE, all outputs 0, illegal=0, instr_cnt=0.
- mem_rdy is ignored outside T1.

Test Plan:
- clr pulse mid-T4 of an add -> same cycle: all outputs 0, busy=0, instr_cnt=0; IDLE held until run.
- run=1, mem_rdy=1, ir=0x2A2B8000 (opcode 00101, Ra=4, Rb=5, Rc=7) -> T0..T5 in 6 cycles:
  - T3: R_wrt=0x0020, Y_rd
  - T4: R_wrt=0x0080, op_sel=00101, Zlo_rd
  - T5: Zlo_out, R_rd=0x0010
  - then instr_cnt=1, back to T0.
- Same instruction with mem_rdy low 3 cycles -> T1 lasts 4 cycles: Read/MDR_rd high throughout, PC_rd high only in the last; total 9 cycles.
- ir opcode 10010, Ra=5, Rb=0 -> T3: R_wrt=0x0001, op_sel=10010, Zlo_rd; T4: Zlo_out, R_rd=0x0020; done in 5 cycles.
- ir opcode 01111, Rb=2, Rc=3 -> T4: Zhi_rd and Zlo_rd; T5: LO_rd; T6: HI_rd with Zhi_out; 7 cycles.
- ir opcode 11111 then 11011 -> illegal=1 after first instruction; halted=1, busy=0 after second; instr_cnt=2; run toggling has no effect until clr.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus datapath: sequences fetch (T0..T2)
// and class-dependent execute steps (T3..T6), with a retired-instruction counter.
module control_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic             mem_rdy,
    input  logic [31:0]      ir,
    output logic [15:0]      R_rd,
    output logic [15:0]      R_wrt,
    output logic             PC_out,
    output logic             MDR_out,
    output logic             Zlo_out,
    output logic             Zhi_out,
    output logic             MAR_rd,
    output logic             PC_rd,
    output logic             MDR_rd,
    output logic             IR_rd,
    output logic             Y_rd,
    output logic             Zlo_rd,
    output logic             Zhi_rd,
    output logic             LO_rd,
    output logic             HI_rd,
    output logic             IncPC,
    output logic             Read,
    output logic [4:0]       op_sel,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_3REG, C_MULDIV, C_2REG, C_NOP, C_HALT, C_ILL
    } class_t;

    state_t state, state_n;
    class_t op_class;

    logic [4:0]  opcode;
    logic [15:0] ra_hot, rb_hot, rc_hot;
    logic        cnt_inc, set_ill, done;
    logic        unused_ir_bits;

    assign opcode         = ir[31:27];
    assign ra_hot         = 16'h0001 << ir[26:23];
    assign rb_hot         = 16'h0001 << ir[22:19];
    assign rc_hot         = 16'h0001 << ir[18:15];
    assign unused_ir_bits = ^ir[14:0];

    always_comb begin
        op_class = C_ILL;
        if (opcode >= 5'd3 && opcode <= 5'd12)        op_class = C_3REG;
        else if (opcode == 5'd15 || opcode == 5'd16)  op_class = C_MULDIV;
        else if (opcode == 5'd17 || opcode == 5'd18)  op_class = C_2REG;
        else if (opcode == 5'd26)                     op_class = C_NOP;
        else if (opcode == 5'd27)                     op_class = C_HALT;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= S_IDLE;
            instr_cnt <= '0;
            illegal   <= 1'b0;
        end else begin
            state <= state_n;
            if (cnt_inc)
                instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (set_ill)
                illegal <= 1'b1;
        end
    end

    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);

    // Execute steps depend on ir only from T3 on; ir is stable by then.
    always_comb begin
        state_n = state;
        done    = 1'b0;
        cnt_inc = 1'b0;
        set_ill = 1'b0;
        R_rd    = '0;
        R_wrt   = '0;
        PC_out  = 1'b0;
        MDR_out = 1'b0;
        Zlo_out = 1'b0;
        Zhi_out = 1'b0;
        MAR_rd  = 1'b0;
        PC_rd   = 1'b0;
        MDR_rd  = 1'b0;
        IR_rd   = 1'b0;
        Y_rd    = 1'b0;
        Zlo_rd  = 1'b0;
        Zhi_rd  = 1'b0;
        LO_rd   = 1'b0;
        HI_rd   = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        op_sel  = '0;

        case (state)
            S_IDLE: begin
                if (run)
                    state_n = S_T0;
            end
            S_T0: begin
                PC_out  = 1'b1;
                MAR_rd  = 1'b1;
                IncPC   = 1'b1;
                Zlo_rd  = 1'b1;
                state_n = S_T1;
            end
            S_T1: begin
                Zlo_out = 1'b1;
                Read    = 1'b1;
                MDR_rd  = 1'b1;
                if (mem_rdy) begin
                    PC_rd   = 1'b1;
                    state_n = S_T2;
                end
            end
            S_T2: begin
                MDR_out = 1'b1;
                IR_rd   = 1'b1;
                state_n = S_T3;
            end
            S_T3: begin
                case (op_class)
                    C_3REG, C_MULDIV: begin
                        R_wrt   = rb_hot;
                        Y_rd    = 1'b1;
                        state_n = S_T4;
                    end
                    C_2REG: begin
                        R_wrt   = rb_hot;
                        op_sel  = opcode;
                        Zlo_rd  = 1'b1;
                        state_n = S_T4;
                    end
                    C_HALT: begin
                        cnt_inc = 1'b1;
                        state_n = S_HALT;
                    end
                    C_NOP: done = 1'b1;
                    default: begin
                        set_ill = 1'b1;
                        done    = 1'b1;
                    end
                endcase
            end
            S_T4: begin
                case (op_class)
                    C_3REG, C_MULDIV: begin
                        R_wrt   = rc_hot;
                        op_sel  = opcode;
                        Zlo_rd  = 1'b1;
                        Zhi_rd  = (op_class == C_MULDIV);
                        state_n = S_T5;
                    end
                    C_2REG: begin
                        Zlo_out = 1'b1;
                        R_rd    = ra_hot;
                        done    = 1'b1;
                    end
                    default: state_n = S_IDLE;
                endcase
            end
            S_T5: begin
                case (op_class)
                    C_3REG: begin
                        Zlo_out = 1'b1;
                        R_rd    = ra_hot;
                        done    = 1'b1;
                    end
                    C_MULDIV: begin
                        Zlo_out = 1'b1;
                        LO_rd   = 1'b1;
                        state_n = S_T6;
                    end
                    default: state_n = S_IDLE;
                endcase
            end
            S_T6: begin
                Zhi_out = 1'b1;
                HI_rd   = 1'b1;
                done    = 1'b1;
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase

        // run is looked at only when an instruction retires.
        if (done) begin
            cnt_inc = 1'b1;
            state_n = run ? S_T0 : S_IDLE;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed and random instructions compared cycle by
// cycle against a micro-step model built from the instruction-class rules.
module tb_control_sequencer;

    localparam int CNT_W = 4;
    localparam int K3 = 0, KMD = 1, K2 = 2, KNOP = 3, KHALT = 4, KILL = 5;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             run = 1'b0;
    logic             mem_rdy = 1'b0;
    logic [31:0]      ir = '0;
    logic [15:0]      R_rd, R_wrt;
    logic             PC_out, MDR_out, Zlo_out, Zhi_out;
    logic             MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, LO_rd, HI_rd;
    logic             IncPC, Read, busy, halted, illegal;
    logic [4:0]       op_sel;
    logic [CNT_W-1:0] instr_cnt;

    typedef struct packed {
        logic [15:0]      r_rd;
        logic [15:0]      r_wrt;
        logic             pc_out, mdr_out, zlo_out, zhi_out;
        logic             mar_rd, pc_rd, mdr_rd, ir_rd, y_rd, zlo_rd, zhi_rd, lo_rd, hi_rd;
        logic             inc_pc, read;
        logic [4:0]       op_sel;
        logic             busy, halted, illegal;
        logic [CNT_W-1:0] instr_cnt;
    } ctl_t;

    ctl_t             obs;
    int               n_checks = 0;
    int               n_fail = 0;
    logic [CNT_W-1:0] cnt_m = '0;
    logic             ill_m = 1'b0;

    control_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr), .run(run), .mem_rdy(mem_rdy), .ir(ir),
        .R_rd(R_rd), .R_wrt(R_wrt),
        .PC_out(PC_out), .MDR_out(MDR_out), .Zlo_out(Zlo_out), .Zhi_out(Zhi_out),
        .MAR_rd(MAR_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd),
        .Zlo_rd(Zlo_rd), .Zhi_rd(Zhi_rd), .LO_rd(LO_rd), .HI_rd(HI_rd),
        .IncPC(IncPC), .Read(Read), .op_sel(op_sel),
        .busy(busy), .halted(halted), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {R_rd, R_wrt, PC_out, MDR_out, Zlo_out, Zhi_out,
                  MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, LO_rd, HI_rd,
                  IncPC, Read, op_sel, busy, halted, illegal, instr_cnt};

    function automatic int cls_of(input logic [4:0] o);
        if (o >= 5'd3 && o <= 5'd12) return K3;
        if (o == 5'd15 || o == 5'd16) return KMD;
        if (o == 5'd17 || o == 5'd18) return K2;
        if (o == 5'd26) return KNOP;
        if (o == 5'd27) return KHALT;
        return KILL;
    endfunction

    function automatic ctl_t base_vec(input logic busy_v, input logic halted_v);
        ctl_t e;
        e           = '0;
        e.busy      = busy_v;
        e.halted    = halted_v;
        e.illegal   = ill_m;
        e.instr_cnt = cnt_m;
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_output(input string tag, input ctl_t exp);
        int drivers;
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        drivers = $countones({R_wrt, PC_out, MDR_out, Zlo_out, Zhi_out});
        n_checks++;
        assert (drivers <= 1) else begin
            n_fail++;
            $error("FAIL %s_bus_drivers observed=%0d required<=1", tag, drivers);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic m, input logic [31:0] i);
        @(negedge clk);
        run     = r;
        mem_rdy = m;
        ir      = i;
        #1;
    endtask

    task automatic idle_cycle(input logic r);
        apply_stimulus(r, rbit(), ir);
        check_output("idle", base_vec(1'b0, 1'b0));
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        run = rbit();
        #1;
        cnt_m = '0;
        ill_m = 1'b0;
        check_output("clr", base_vec(1'b0, 1'b0));
        @(negedge clk);
        clr = 1'b0;
        run = 1'b0;
        #1;
        check_output("clr_release", base_vec(1'b0, 1'b0));
    endtask

    // Builds the expected micro-step list for one instruction, then plays it.
    task automatic do_instr(input logic [31:0] instr, input int waits,
                            input logic run_after, input int abort_at);
        ctl_t       q[$];
        logic       mq[$];
        string      tq[$];
        ctl_t       e;
        logic [4:0] opc;
        int         cls;
        logic       r;
        opc = instr[31:27];
        cls = cls_of(opc);

        e = base_vec(1'b1, 1'b0);
        e.pc_out = 1; e.mar_rd = 1; e.inc_pc = 1; e.zlo_rd = 1;
        q.push_back(e); mq.push_back(rbit()); tq.push_back("T0");
        for (int w = 0; w <= waits; w++) begin
            e = base_vec(1'b1, 1'b0);
            e.zlo_out = 1; e.read = 1; e.mdr_rd = 1; e.pc_rd = (w == waits);
            q.push_back(e); mq.push_back(w == waits); tq.push_back("T1");
        end
        e = base_vec(1'b1, 1'b0);
        e.mdr_out = 1; e.ir_rd = 1;
        q.push_back(e); mq.push_back(rbit()); tq.push_back("T2");

        if (cls == K3 || cls == KMD) begin
            e = base_vec(1'b1, 1'b0);
            e.r_wrt = 16'h1 << instr[22:19]; e.y_rd = 1;
            q.push_back(e); tq.push_back("T3");
            e = base_vec(1'b1, 1'b0);
            e.r_wrt = 16'h1 << instr[18:15]; e.op_sel = opc; e.zlo_rd = 1;
            e.zhi_rd = (cls == KMD);
            q.push_back(e); tq.push_back("T4");
            e = base_vec(1'b1, 1'b0);
            e.zlo_out = 1;
            if (cls == K3) e.r_rd = 16'h1 << instr[26:23];
            else           e.lo_rd = 1;
            q.push_back(e); tq.push_back("T5");
            if (cls == KMD) begin
                e = base_vec(1'b1, 1'b0);
                e.zhi_out = 1; e.hi_rd = 1;
                q.push_back(e); tq.push_back("T6");
            end
        end else if (cls == K2) begin
            e = base_vec(1'b1, 1'b0);
            e.r_wrt = 16'h1 << instr[22:19]; e.op_sel = opc; e.zlo_rd = 1;
            q.push_back(e); tq.push_back("T3");
            e = base_vec(1'b1, 1'b0);
            e.zlo_out = 1; e.r_rd = 16'h1 << instr[26:23];
            q.push_back(e); tq.push_back("T4");
        end else begin
            q.push_back(base_vec(1'b1, 1'b0)); tq.push_back("T3");
        end
        while (mq.size() < q.size()) mq.push_back(rbit());

        for (int k = 0; k < q.size(); k++) begin
            if (k == abort_at) begin
                pulse_clr();
                return;
            end
            r = (k == q.size() - 1) ? run_after : rbit();
            apply_stimulus(r, mq[k], instr);
            check_output(tq[k], q[k]);
        end
        cnt_m = cnt_m + 1'b1;
        if (cls == KILL) ill_m = 1'b1;
    endtask

    initial begin
        logic [31:0] rnd_ir;
        logic        ra;
        #1 clr = 1'b1;
        @(negedge clk);
        #1;
        check_output("reset", base_vec(1'b0, 1'b0));
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_output("reset_release", base_vec(1'b0, 1'b0));
        idle_cycle(1'b1);

        $display("[TB] directed instructions");
        do_instr(32'h2A2B8000, 0, 1'b1, -1);
        do_instr(32'h2A2B8000, 3, 1'b1, -1);
        do_instr({5'b10010, 4'd5, 4'd0, 4'd0, 15'd0}, 0, 1'b1, -1);
        do_instr({5'b01111, 4'd0, 4'd2, 4'd3, 15'd0}, 1, 1'b1, -1);
        do_instr({5'b11111, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 1'b0, -1);
        idle_cycle(1'b0);
        idle_cycle(1'b1);

        $display("[TB] clr in T4 and in T1 wait");
        do_instr(32'h2A2B8000, 0, 1'b1, 4);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        do_instr(32'h2A2B8000, 3, 1'b1, 2);
        idle_cycle(1'b1);

        $display("[TB] random instructions");
        for (int n = 0; n < 40; n++) begin
            rnd_ir = $urandom;
            if (rnd_ir[31:27] == 5'd27) rnd_ir[31:27] = 5'd26;
            ra = ($urandom_range(0, 3) != 0);
            do_instr(rnd_ir, $urandom_range(0, 3), ra, -1);
            if (!ra) begin
                idle_cycle(1'b0);
                idle_cycle(1'b1);
            end
        end

        $display("[TB] illegal then halt");
        pulse_clr();
        idle_cycle(1'b1);
        do_instr({5'b11111, 4'd0, 4'd0, 4'd0, 15'd0}, 0, 1'b1, -1);
        do_instr({5'b11011, 4'd0, 4'd0, 4'd0, 15'd0}, 1, 1'b1, -1);
        for (int h = 0; h < 6; h++) begin
            apply_stimulus(h[0], rbit(), ir);
            check_output("halt", base_vec(1'b0, 1'b1));
        end
        pulse_clr();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
